// File: rtl/mem_access.sv
// Memory stage: lane-aware loads and stores over a single-port word bus, read-modify-write for
// sub-word stores, misaligned accesses dropped, bus timeout abort and writeback register.
module mem_access #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r_mem_enable_i,
  input  logic [31:0] r_mem_addr_i,
  input  logic        w_mem_enable_i,
  input  logic [31:0] w_mem_addr_i,
  input  logic [31:0] w_mem_data_i,
  input  logic [2:0]  data_type_i,
  input  logic        ex_w_reg_enable_i,
  input  logic        mem_w_reg_enable_i,
  input  logic [4:0]  w_reg_addr_i,
  input  logic [31:0] ex_w_reg_data_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stall_o,
  output logic        w_reg_enable_o,
  output logic [4:0]  w_reg_addr_o,
  output logic [31:0] w_reg_data_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CYC - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD     = 3'd1;
  localparam logic [2:0] WR     = 3'd2;
  localparam logic [2:0] RMW_RD = 3'd3;
  localparam logic [2:0] RMW_WR = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     merged_q, merged_d;
  logic            w_reg_enable_q, w_reg_enable_d;
  logic [4:0]      w_reg_addr_q, w_reg_addr_d;
  logic [31:0]     w_reg_data_q, w_reg_data_d;
  logic            misalign_q, misalign_d;
  logic            bus_err_q, bus_err_d;

  logic        type_byte, type_half, type_word, type_valid;
  logic        is_store, mem_op, misaligned;
  logic [31:0] addr;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data, rmw_word;
  logic        bus_req, stall;

  assign type_byte  = (data_type_i[1:0] == 2'b01);
  assign type_half  = (data_type_i[1:0] == 2'b10);
  assign type_word  = (data_type_i == 3'b011);
  assign type_valid = type_byte | type_half | type_word;

  // A simultaneous load and store request is handled as the store.
  assign is_store   = w_mem_enable_i;
  assign mem_op     = (r_mem_enable_i | w_mem_enable_i) & type_valid;
  assign addr       = is_store ? w_mem_addr_i : r_mem_addr_i;
  assign misaligned = (type_half & addr[0]) | (type_word & (addr[1:0] != 2'b00));

  assign ld_byte = bus_rdata_i[{addr[1:0], 3'b000} +: 8];
  assign ld_half = bus_rdata_i[{addr[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = bus_rdata_i;
    if (type_byte) begin
      ld_data = {{24{ld_byte[7] & ~data_type_i[2]}}, ld_byte};
    end else if (type_half) begin
      ld_data = {{16{ld_half[15] & ~data_type_i[2]}}, ld_half};
    end
  end

  always_comb begin
    rmw_word = bus_rdata_i;
    if (type_byte) begin
      rmw_word[{addr[1:0], 3'b000} +: 8] = w_mem_data_i[7:0];
    end else begin
      rmw_word[{addr[1], 4'b0000} +: 16] = w_mem_data_i[15:0];
    end
  end

  assign bus_req = (state_q != IDLE);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    merged_d       = merged_q;
    w_reg_enable_d = 1'b0;
    w_reg_addr_d   = w_reg_addr_q;
    w_reg_data_d   = w_reg_data_q;
    misalign_d     = 1'b0;
    bus_err_d      = 1'b0;
    stall          = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (mem_op) begin
          if (misaligned) begin
            misalign_d = 1'b1;
          end else begin
            stall = 1'b1;
            if (!is_store)      state_d = RD;
            else if (type_word) state_d = WR;
            else                state_d = RMW_RD;
          end
        end else if (ex_w_reg_enable_i) begin
          w_reg_enable_d = 1'b1;
          w_reg_addr_d   = w_reg_addr_i;
          w_reg_data_d   = ex_w_reg_data_i;
        end
      end
      RD: begin
        if (bus_ack_i) begin
          state_d        = IDLE;
          w_reg_enable_d = mem_w_reg_enable_i;
          w_reg_addr_d   = w_reg_addr_i;
          w_reg_data_d   = ld_data;
        end else begin
          stall = 1'b1;
        end
      end
      WR, RMW_WR: begin
        if (bus_ack_i) state_d = IDLE;
        else           stall   = 1'b1;
      end
      RMW_RD: begin
        stall = 1'b1;
        if (bus_ack_i) begin
          merged_d = rmw_word;
          state_d  = RMW_WR;
          cnt_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // An ack arriving in the limit cycle completes normally.
    if (bus_req && !bus_ack_i) begin
      if (cnt_q == CntLimit) begin
        state_d   = IDLE;
        cnt_d     = '0;
        bus_err_d = 1'b1;
        stall     = 1'b0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      merged_q       <= '0;
      w_reg_enable_q <= 1'b0;
      w_reg_addr_q   <= '0;
      w_reg_data_q   <= '0;
      misalign_q     <= 1'b0;
      bus_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      merged_q       <= merged_d;
      w_reg_enable_q <= w_reg_enable_d;
      w_reg_addr_q   <= w_reg_addr_d;
      w_reg_data_q   <= w_reg_data_d;
      misalign_q     <= misalign_d;
      bus_err_q      <= bus_err_d;
    end
  end

  assign bus_req_o      = bus_req;
  assign bus_we_o       = (state_q == WR) | (state_q == RMW_WR);
  assign bus_addr_o     = bus_req ? {addr[31:2], 2'b00} : 32'h0;
  assign bus_wdata_o    = (state_q == WR)     ? w_mem_data_i :
                          (state_q == RMW_WR) ? merged_q     : 32'h0;
  assign stall_o        = stall;
  assign w_reg_enable_o = w_reg_enable_q;
  assign w_reg_addr_o   = w_reg_addr_q;
  assign w_reg_data_o   = w_reg_data_q;
  assign misalign_o     = misalign_q;
  assign bus_err_o      = bus_err_q;

endmodule
